// File: rtl/fv_bank_requester_if.sv
// Bundle between one Edge PE requester and its surroundings: PE command/write/read
// channels, the bank request packet and the tagged bank response stream.
interface fv_bank_requester_if #(
    parameter int TAG_W  = 2,
    parameter int NODE_W = 10,
    parameter int FV_BW  = 16,
    parameter int BEAT_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rd_wr;
    logic [NODE_W-1:0] cmd_node_id;
    logic [BEAT_W-1:0] cmd_beats;

    logic              wr_valid;
    logic              wr_ready;
    logic [FV_BW-1:0]  wr_data;

    logic              bank_available;

    logic              req_pkt_valid;
    logic              req_pkt_rd_wr;
    logic              req_pkt_wr_sos;
    logic              req_pkt_wr_eos;
    logic [TAG_W-1:0]  req_pkt_PE_tag;
    logic [NODE_W-1:0] req_pkt_Node_id;
    logic [FV_BW-1:0]  req_pkt_data;

    logic              rsp_valid;
    logic              rsp_sos;
    logic              rsp_eos;
    logic [TAG_W-1:0]  rsp_PE_tag;
    logic [FV_BW-1:0]  rsp_FV_data;

    logic              rd_valid;
    logic              rd_last;
    logic [FV_BW-1:0]  rd_data;

    logic              busy;
    logic              err;

    // master: the requester itself; slave: the PE datapath plus bank side
    modport master (
        input  cmd_valid, cmd_rd_wr, cmd_node_id, cmd_beats,
        input  wr_valid, wr_data, bank_available,
        input  rsp_valid, rsp_sos, rsp_eos, rsp_PE_tag, rsp_FV_data,
        output cmd_ready, wr_ready,
        output req_pkt_valid, req_pkt_rd_wr, req_pkt_wr_sos, req_pkt_wr_eos,
        output req_pkt_PE_tag, req_pkt_Node_id, req_pkt_data,
        output rd_valid, rd_last, rd_data, busy, err
    );

    modport slave (
        output cmd_valid, cmd_rd_wr, cmd_node_id, cmd_beats,
        output wr_valid, wr_data, bank_available,
        output rsp_valid, rsp_sos, rsp_eos, rsp_PE_tag, rsp_FV_data,
        input  cmd_ready, wr_ready,
        input  req_pkt_valid, req_pkt_rd_wr, req_pkt_wr_sos, req_pkt_wr_eos,
        input  req_pkt_PE_tag, req_pkt_Node_id, req_pkt_data,
        input  rd_valid, rd_last, rd_data, busy, err
    );
endinterface

// File: rtl/fv_bank_requester.sv
// Edge-PE initiator for one Big FV bank port: issues read/write request packets
// and collects this PE's tagged read response stream beat by beat.
module fv_bank_requester #(
    parameter int PE_TAG  = 0,
    parameter int TAG_W   = 2,
    parameter int NODE_W  = 10,
    parameter int FV_BW   = 16,
    parameter int BEAT_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fv_bank_requester_if.master   bus_io
);
    typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_STREAM} state_t;

    state_t            state_q, state_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              ovf_q, ovf_d;

    logic              req_valid_q, req_valid_d;
    logic              req_rd_wr_q, req_rd_wr_d;
    logic              req_sos_q, req_sos_d;
    logic              req_eos_q, req_eos_d;
    logic [FV_BW-1:0]  req_data_q, req_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [FV_BW-1:0]  rd_data_q, rd_data_d;
    logic              err_q, err_d;

    // One bit wider than the counter so "count including this beat" never wraps
    logic [BEAT_W:0]   cnt_inc;
    logic [BEAT_W:0]   beats_ext;
    logic              rsp_hit;

    assign cnt_inc   = {1'b0, cnt_q} + (BEAT_W+1)'(1);
    assign beats_ext = {1'b0, beats_q};
    assign rsp_hit   = bus_io.rsp_valid && (bus_io.rsp_PE_tag == TAG_W'(PE_TAG));

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        ovf_d       = ovf_q;
        req_valid_d = 1'b0;
        req_rd_wr_d = 1'b0;
        req_sos_d   = 1'b0;
        req_eos_d   = 1'b0;
        req_data_d  = '0;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        rd_data_d   = '0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus_io.cmd_valid) begin
                    node_d  = bus_io.cmd_node_id;
                    beats_d = bus_io.cmd_beats;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    ovf_d   = 1'b0;
                    if (bus_io.cmd_beats == '0) begin
                        err_d = 1'b1;
                    end else if (bus_io.cmd_rd_wr) begin
                        state_d = S_WR_STREAM;
                    end else if (bus_io.bank_available) begin
                        // Bank free at accept time: issue the read request straight away
                        req_valid_d = 1'b1;
                        state_d     = S_RD_WAIT;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                if (bus_io.bank_available) begin
                    req_valid_d = 1'b1;
                    state_d     = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (rsp_hit) begin
                    tmo_d = '0;
                    if ((cnt_q == '0) && !bus_io.rsp_sos) begin
                        err_d = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus_io.rsp_FV_data;
                        cnt_d      = (cnt_q == {BEAT_W{1'b1}}) ? cnt_q : cnt_q + BEAT_W'(1);
                        if (bus_io.rsp_eos) begin
                            rd_last_d = 1'b1;
                            err_d     = (cnt_inc != beats_ext);
                            state_d   = S_IDLE;
                        end else if ((cnt_inc > beats_ext) && !ovf_q) begin
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q + 8'd1 == 8'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_WR_STREAM: begin
                if (bus_io.wr_valid && bus_io.bank_available) begin
                    req_valid_d = 1'b1;
                    req_rd_wr_d = 1'b1;
                    req_data_d  = bus_io.wr_data;
                    req_sos_d   = (cnt_q == '0);
                    req_eos_d   = (cnt_inc == beats_ext);
                    cnt_d       = cnt_q + BEAT_W'(1);
                    if (cnt_inc == beats_ext) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            node_q      <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ovf_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_rd_wr_q <= 1'b0;
            req_sos_q   <= 1'b0;
            req_eos_q   <= 1'b0;
            req_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
            req_valid_q <= req_valid_d;
            req_rd_wr_q <= req_rd_wr_d;
            req_sos_q   <= req_sos_d;
            req_eos_q   <= req_eos_d;
            req_data_q  <= req_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.cmd_ready       = (state_q == S_IDLE);
    assign bus_io.wr_ready        = (state_q == S_WR_STREAM) && bus_io.bank_available;
    assign bus_io.req_pkt_valid   = req_valid_q;
    assign bus_io.req_pkt_rd_wr   = req_rd_wr_q;
    assign bus_io.req_pkt_wr_sos  = req_sos_q;
    assign bus_io.req_pkt_wr_eos  = req_eos_q;
    assign bus_io.req_pkt_PE_tag  = TAG_W'(PE_TAG);
    assign bus_io.req_pkt_Node_id = node_q;
    assign bus_io.req_pkt_data    = req_data_q;
    assign bus_io.rd_valid        = rd_valid_q;
    assign bus_io.rd_last         = rd_last_q;
    assign bus_io.rd_data         = rd_data_q;
    assign bus_io.busy            = (state_q != S_IDLE);
    assign bus_io.err             = err_q;
endmodule
